fp_sig_mul_seq: RTL and testbench
=================================

FP_SIG_MUL_SEQ -- requirements
Module: fp_sig_mul_seq

Interface
REQ-001 SHALL have parameter NEXP, default 8, exponent width; carried for instance consistency with the floating-point multiplier, unused in the datapath.
REQ-002 SHALL have parameter NSIG, default 23, stored-fraction width; significand operands are NSIG+1 bits wide.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair A/B is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port A  input  NSIG+1  unsigned significand, hidden bit included.
REQ-008 SHALL have port B  input  NSIG+1  unsigned significand, hidden bit included.
REQ-009 SHALL have port out_valid  output  1  Z holds a completed product.
REQ-010 SHALL have port out_ready  input  1  consumer takes Z this cycle.
REQ-011 SHALL have port Z  output  2*NSIG+2  exact unsigned product A*B, same layout as the multiplier's raw significand.
REQ-012 SHALL have port busy  output  1  high in RUN.

Function
REQ-013 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready high in IDLE, and in DONE when out_ready is high; low otherwise.
REQ-015 SHALL accept operands on an edge where in_valid and in_ready are both high: capture A as the multiplicand, load B into the low half of a 2*NSIG+2 bit product register with the high half zeroed, and clear the iteration counter.
REQ-016 SHALL treat an accepted pair with A==0 or B==0 as a shortcut: go directly to DONE with Z=0, one cycle after acceptance.
REQ-017 SHALL otherwise enter RUN and perform exactly NSIG+1 radix-2 shift-add steps, one per cycle.
REQ-018 SHALL compute each step as: if product-register bit 0 is set, add the multiplicand into the high NSIG+1 bits using an NSIG+2 bit sum, keeping the carry; then shift the whole register, including that carry, right by one.
REQ-019 SHALL use an iteration counter of width $clog2(NSIG+2) and move RUN->DONE on the step that completes iteration NSIG+1.
REQ-020 SHALL give latency from acceptance edge to out_valid high of exactly NSIG+1 cycles for non-zero operands.
REQ-021 SHALL, in DONE, hold out_valid high with Z stable until out_ready is high.
REQ-022 SHALL, in DONE with out_ready high and in_valid low, go to IDLE and drop out_valid on the next edge.
REQ-023 SHALL, in DONE with out_ready and in_valid both high, accept the new pair in the same cycle (back-to-back, no bubble).
REQ-024 SHALL ignore in_valid while in RUN, with in_ready held low.
REQ-025 SHALL keep Z at its last delivered value outside DONE; Z carries no meaning while out_valid is low.

Reset
REQ-026 SHALL, while rst is high at any time (including mid-RUN), force state IDLE, the counter to 0, the product and multiplicand registers to 0, out_valid=0, busy=0 and Z=0, and SHALL drop any in-flight operation.
REQ-027 SHALL drive in_ready=1 during reset and on release (IDLE).

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/DONE) and a width helper for the counter from the shared package fp_mul_pkg; NSIG-derived widths stay as module parameters.
REQ-029 SHALL be a single module with no sub-module; the step adder and counter are inline, and the block replaces the combinational significand multiplier ahead of the rounding/packing stage.

Verification
REQ-030 SHALL pass this scenario: NSIG=23, A=B=24'hC00000 -> Z=48'h900000000000, out_valid high exactly 24 cycles after acceptance.
REQ-031 SHALL pass this scenario: NSIG=23, A=B=24'hFFFFFF -> Z=48'hFFFFFE000001, latency 24.
REQ-032 SHALL pass this scenario: A=24'h000000, B=24'h800000 -> Z=0, out_valid 1 cycle after acceptance.
REQ-033 SHALL pass this scenario: out_ready held low 5 cycles in DONE -> Z and out_valid stable for all 5 cycles; a second pair presented with out_ready high is accepted in the same cycle and its result appears 24 cycles later.
REQ-034 SHALL pass this scenario: rst pulsed at step 10 of RUN -> outputs cleared, in_ready=1 after release, no out_valid for the aborted pair; a fresh pair then completes correctly.
REQ-035 SHALL pass this scenario: NSIG=10, A=B=11'h400 -> Z=22'h100000, latency 11.

Source files
------------

// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pkg
//  Description : Shared types and helpers for the floating-point multiplier
//                family (state encoding, counter width helper).
//  Revision    : 1.0  initial release
// ============================================================================
package fp_mul_pkg;

  // Control states of the sequential significand multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Iteration counter width for an NSIG-bit stored fraction
  function automatic int cnt_width(input int nsig);
    return $clog2(nsig + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_sig_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sig_mul_seq
//  Description : Radix-2 shift-add sequential multiplier for (NSIG+1)-bit
//                unsigned significands. Produces the exact 2*NSIG+2 bit
//                product after NSIG+1 iterations, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_sig_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSIG:0]     A,
  input  logic [NSIG:0]     B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NSIG+1:0] Z,
  output logic              busy
);

  localparam int SW = NSIG + 1;
  localparam int PW = 2 * NSIG + 2;
  localparam int CW = cnt_width(NSIG);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSIG);

  // The exponent width only has to be sane; the datapath never uses it
  if (NEXP < 1) begin : g_nexp_check
    $error("fp_sig_mul_seq: NEXP must be at least 1");
  end

  mul_state_t     state, state_next;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  prod;
  logic [SW-1:0]  mcand;
  logic [PW-1:0]  z_hold;

  logic           accept;
  logic           zero_op;
  logic           last_step;
  logic [SW:0]    addend;
  logic [SW:0]    sum;
  logic [PW-1:0]  step_next;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign zero_op   = (A == '0) || (B == '0);
  assign last_step = (cnt == LAST_STEP);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign Z         = z_hold;

  // One shift-add step: conditional add into the high half, carry kept, shift right
  assign addend    = prod[0] ? {1'b0, mcand} : '0;
  assign sum       = {1'b0, prod[PW-1:SW]} + addend;
  assign step_next = {sum, prod[SW-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result hold.
  // A zero operand loads a cleared register with the counter already at the
  // last step, so a single idle step lands in DONE with a zero product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      z_hold <= '0;
    end else if (accept) begin
      if (zero_op) begin
        mcand <= '0;
        prod  <= '0;
        cnt   <= LAST_STEP;
      end else begin
        mcand <= A;
        prod  <= {{SW{1'b0}}, B};
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      prod <= step_next;
      cnt  <= cnt + CW'(1);
      if (last_step) z_hold <= step_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_sig_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_sig_mul_seq
//  Description : Self-checking bench for fp_sig_mul_seq (NSIG=23 and NSIG=10)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_sig_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a_in = '0;
  logic [23:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] z_out;
  logic        busy;

  logic        in_valid10 = 1'b0;
  logic        in_ready10;
  logic [10:0] a10 = '0;
  logic [10:0] b10 = '0;
  logic        out_valid10;
  logic        out_ready10 = 1'b0;
  logic [21:0] z10;
  logic        busy10;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [47:0] sb[$];
  logic [21:0] sb10[$];

  always #5 clk = ~clk;

  fp_sig_mul_seq #(.NEXP(8), .NSIG(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .A(a_in), .B(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .Z(z_out), .busy(busy)
  );

  fp_sig_mul_seq #(.NEXP(5), .NSIG(10)) dut10 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid10), .in_ready(in_ready10), .A(a10), .B(b10),
    .out_valid(out_valid10), .out_ready(out_ready10), .Z(z10), .busy(busy10)
  );

  // Present a pair until accepted; push the reference product. Returns at posedge+1.
  task automatic accept(input logic [23:0] a, input logic [23:0] b);
    int guard;
    a_in = a; b_in = b; in_valid = 1'b1;
    guard = 0;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    sb.push_back(48'(a) * 48'(b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid; returns at a negedge.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Take the held result
  task automatic deliver();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (z_out !== 48'h0) $display("FAIL rst_z: got %h want 0", z_out); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_scenario_pairs();
    logic [23:0] av[3] = '{24'hC00000, 24'hFFFFFF, 24'h800000};
    logic [23:0] bv[3] = '{24'hC00000, 24'hFFFFFF, 24'hFFFFFF};
    logic [47:0] fixed[3] = '{48'h900000000000, 48'hFFFFFE000001, 48'h7FFFFF800000};
    logic [47:0] exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      accept(av[i], bv[i]);
      total_cnt++; if (busy !== 1'b1) $display("FAIL pair%0d_busy: got %b want 1", i, busy); else pass_cnt++;
      wait_valid(lat);
      total_cnt++; if (lat !== 24) $display("FAIL pair%0d_latency: got %0d want 24", i, lat); else pass_cnt++;
      exp = sb.pop_front();
      total_cnt++; if (z_out !== fixed[i]) $display("FAIL pair%0d_z: got %h want %h", i, z_out, fixed[i]); else pass_cnt++;
      total_cnt++; if (z_out !== exp) $display("FAIL pair%0d_sb: got %h want %h", i, z_out, exp); else pass_cnt++;
      deliver();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL pair%0d_drop: got %b want 0", i, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [47:0] exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept(24'($urandom_range(1, 24'hFFFFFF)), 24'($urandom_range(1, 24'hFFFFFF)));
      wait_valid(lat);
      total_cnt++; if (lat !== 24) $display("FAIL rnd%0d_latency: got %0d want 24", i, lat); else pass_cnt++;
      exp = sb.pop_front();
      total_cnt++; if (z_out !== exp) $display("FAIL rnd%0d_z: got %h want %h", i, z_out, exp); else pass_cnt++;
      deliver();
    end
  endtask

  task automatic test_zero();
    logic [23:0] av[2] = '{24'h000000, 24'hABCDEF};
    logic [23:0] bv[2] = '{24'h800000, 24'h000000};
    logic [47:0] exp;
    int lat;
    for (int i = 0; i < 2; i++) begin
      accept(av[i], bv[i]);
      wait_valid(lat);
      total_cnt++; if (lat !== 1) $display("FAIL zero%0d_latency: got %0d want 1", i, lat); else pass_cnt++;
      exp = sb.pop_front();
      total_cnt++; if (z_out !== exp) $display("FAIL zero%0d_z: got %h want %h", i, z_out, exp); else pass_cnt++;
      deliver();
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp;
    int lat;
    accept(24'h123456, 24'hABCDEF);
    wait_valid(lat);
    total_cnt++; if (lat !== 24) $display("FAIL b2b_first_latency: got %0d want 24", lat); else pass_cnt++;
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold%0d_valid: got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (z_out !== exp) $display("FAIL hold%0d_z: got %h want %h", i, z_out, exp); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold%0d_in_ready: got %b want 0", i, in_ready); else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready); else pass_cnt++;
    accept(24'hFEDCBA, 24'h987654);
    out_ready = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else pass_cnt++;
    wait_valid(lat);
    total_cnt++; if (lat !== 24) $display("FAIL b2b_second_latency: got %0d want 24", lat); else pass_cnt++;
    exp = sb.pop_front();
    total_cnt++; if (z_out !== exp) $display("FAIL b2b_second_z: got %h want %h", z_out, exp); else pass_cnt++;
    deliver();
  endtask

  task automatic test_abort();
    logic [47:0] exp;
    int lat;
    bit seen;
    accept(24'hD00001, 24'hE00003);
    repeat (10) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (z_out !== 48'h0) $display("FAIL abort_z: got %h want 0", z_out); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sb10.delete();
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_release_ready: got %b want 1", in_ready); else pass_cnt++;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_valid: got %b want 0", seen); else pass_cnt++;
    accept(24'h9ABCDE, 24'hC0FFEE);
    wait_valid(lat);
    total_cnt++; if (lat !== 24) $display("FAIL fresh_latency: got %0d want 24", lat); else pass_cnt++;
    exp = sb.pop_front();
    total_cnt++; if (z_out !== exp) $display("FAIL fresh_z: got %h want %h", z_out, exp); else pass_cnt++;
    deliver();
  endtask

  task automatic test_nsig10();
    logic [21:0] exp;
    int lat;
    a10 = 11'h400; b10 = 11'h400; in_valid10 = 1'b1;
    #1;
    total_cnt++; if (in_ready10 !== 1'b1) $display("FAIL n10_in_ready: got %b want 1", in_ready10); else pass_cnt++;
    sb10.push_back(22'(a10) * 22'(b10));
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid10 && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    total_cnt++; if (lat !== 11) $display("FAIL n10_latency: got %0d want 11", lat); else pass_cnt++;
    exp = sb10.pop_front();
    total_cnt++; if (z10 !== 22'h100000) $display("FAIL n10_z: got %h want 100000", z10); else pass_cnt++;
    total_cnt++; if (z10 !== exp) $display("FAIL n10_sb: got %h want %h", z10, exp); else pass_cnt++;
    out_ready10 = 1'b1;
    @(posedge clk); #1;
    out_ready10 = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid10 !== 1'b0) $display("FAIL n10_drop: got %b want 0", out_valid10); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_scenario_pairs();
    test_random();
    test_zero();
    test_back_to_back();
    test_abort();
    test_nsig10();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
